hazard_controller: RTL and testbench



---
 rtl/hazard_controller.sv | 136 +++++++++++++
 tb/tb_hazard_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard control for the five-stage RV32I core: operand forwarding, load-use bubbles,
// branch flushes and a freeze while a multi-cycle data-memory access is outstanding.
module hazard_controller #(
  parameter int unsigned DATA_WIDTH             = 32,
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
  parameter int unsigned MAX_WAIT               = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
  input  logic [1:0]                        ResultSrcE,
  input  logic                              PCSrcE,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
  input  logic                              RegWriteM,
  input  logic                              RegWriteW,
  input  logic                              MemReqM,
  input  logic                              MemReadyM,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic                              StallF,
  output logic                              StallD,
  output logic                              StallE,
  output logic                              StallM,
  output logic                              FlushD,
  output logic                              FlushE,
  output logic                              FlushW,
  output logic                              MemErr,
  output logic [DATA_WIDTH-1:0]             StallCount
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state_q;
  logic [CntW-1:0]       wait_cnt_q;
  logic                  mem_err_q;
  logic [DATA_WIDTH-1:0] stall_cnt_q;

  logic mem_stall;
  logic load_use;

  always_comb begin
    mem_stall = ((state_q == StIdle) && MemReqM && !MemReadyM) ||
                ((state_q == StWait) && !MemReadyM);
    load_use  = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Memory freeze outranks branch flush, which outranks the load-use bubble.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Memory-stage result wins over write-back since it is the younger write.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
      ForwardAE = 2'b01;
    end
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
      ForwardBE = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (MemReqM && !MemReadyM) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (MemReadyM) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
          end else begin
            if (wait_cnt_q != CntW'(MAX_WAIT)) begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            // Flag fires on the edge the counter reaches MAX_WAIT; the access keeps waiting.
            if (wait_cnt_q >= CntW'(MAX_WAIT - 1)) begin
              mem_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          wait_cnt_q <= '0;
        end
      endcase
      if (StallF && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed test-plan scenarios followed by randomized traffic, all scored against a
// cycle-level reference model of the hazard rules.
module tb_hazard_controller;

  localparam int unsigned DW       = 8;
  localparam int unsigned AW       = 5;
  localparam int unsigned MAX_WAIT = 4;
  localparam int          CNT_MAX  = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [DW-1:0] StallCount;

  hazard_controller #(
    .DATA_WIDTH(DW),
    .REGISTER_ADDRESS_WIDTH(AW),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: is an access outstanding, how many cycles it has waited, sticky error,
  // and the number of fetch-stall cycles seen since reset.
  bit m_busy;
  int m_waited;
  bit m_err;
  int m_stalls;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Called just after a falling edge with inputs set: check outputs, advance model, move on.
  task automatic tick();
    bit mem, lu, sf, sd, se, sm, fd, fe, fw;
    #1;
    if (!rst_n) begin
      m_busy = 0; m_waited = 0; m_err = 0; m_stalls = 0;
    end
    mem = !MemReadyM && (m_busy || MemReqM);
    lu  = ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    {sf, sd, se, sm, fd, fe, fw} = '0;
    if (mem) begin
      {sf, sd, se, sm, fw} = '1;
    end else if (PCSrcE) begin
      {fd, fe} = '1;
    end else if (lu) begin
      {sf, sd, fe} = '1;
    end
    check_eq("fwd_a", 32'(ForwardAE), 32'(fwd_ref(Rs1E)));
    check_eq("fwd_b", 32'(ForwardBE), 32'(fwd_ref(Rs2E)));
    check_eq("stalls", 32'({StallF, StallD, StallE, StallM}), 32'({sf, sd, se, sm}));
    check_eq("flushes", 32'({FlushD, FlushE, FlushW}), 32'({fd, fe, fw}));
    check_eq("mem_err", 32'(MemErr), 32'(m_err));
    check_eq("stall_count", 32'(StallCount), 32'(m_stalls));
    if (rst_n) begin
      if (m_busy && !MemReadyM) begin
        if (m_waited < MAX_WAIT) m_waited++;
        if (m_waited >= MAX_WAIT) m_err = 1;
      end
      m_busy = mem;
      if (!mem) m_waited = 0;
      if (sf && m_stalls < CNT_MAX) m_stalls++;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    check_eq("reset_all_zero", 32'({ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                                    FlushD, FlushE, FlushW, MemErr, StallCount}), 32'd0);
    rst_n = 1'b1;

    // Forwarding: memory stage beats write-back, then write-back alone.
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
    #1;
    check_eq("fwd_mem_prio", 32'({ForwardAE, ForwardBE}), 32'b1000);
    tick();
    RegWriteM = 0;
    #1;
    check_eq("fwd_wb", 32'(ForwardAE), 32'b01);
    tick();
    clear_inputs();

    // Load-use bubble, three cycles.
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    for (int i = 0; i < 3; i++) tick();
    check_eq("load_use_count", 32'(StallCount), 32'd3);
    #1;
    check_eq("load_use_sig", 32'({StallF, StallD, FlushE, FlushD}), 32'b1110);
    RdE = 0; Rs2D = 0;
    #1;
    check_eq("load_use_x0", 32'({StallF, StallD, FlushE}), 32'b000);
    tick();

    // Branch wins over load-use.
    RdE = 7; Rs2D = 7; PCSrcE = 1;
    #1;
    check_eq("branch_vs_lu", 32'({FlushD, FlushE, StallF, StallD}), 32'b1100);
    tick();
    clear_inputs();

    // Memory wait of three stalled cycles, released on the fourth.
    do_reset();
    MemReqM = 1;
    for (int i = 0; i < 3; i++) tick();
    MemReadyM = 1;
    #1;
    check_eq("mem_release", 32'({StallF, StallM, FlushW}), 32'b000);
    tick();
    check_eq("mem_wait_count", 32'(StallCount), 32'd3);
    // Zero-wait access.
    MemReqM = 1; MemReadyM = 1;
    #1;
    check_eq("zero_wait", 32'(StallF), 32'd0);
    tick();
    clear_inputs();
    MemReadyM = 1;
    tick();

    // Timeout: ready low for six cycles.
    clear_inputs();
    MemReqM = 1;
    for (int i = 0; i < 4; i++) tick();
    check_eq("timeout_early", 32'(MemErr), 32'd0);
    tick();
    check_eq("timeout_set", 32'(MemErr), 32'd1);
    tick();
    MemReadyM = 1;
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) tick();
    check_eq("timeout_sticky", 32'(MemErr), 32'd1);

    // Reset while stalled.
    MemReqM = 1;
    tick();
    tick();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_wait", 32'({StallF, StallM, FlushW, MemErr, StallCount}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    MemReadyM = 1;
    tick();
    MemReadyM = 0;
    #1;
    check_eq("rst_stays_idle", 32'(StallF), 32'd0);
    tick();

    // Randomized traffic, with the occasional reset pulse.
    for (int i = 0; i < 3000; i++) begin
      Rs1D = AW'($urandom_range(0, 3)); Rs2D = AW'($urandom_range(0, 3));
      Rs1E = AW'($urandom_range(0, 3)); Rs2E = AW'($urandom_range(0, 3));
      RdE  = AW'($urandom_range(0, 3)); RdM  = AW'($urandom_range(0, 3));
      RdW  = AW'($urandom_range(0, 3));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 5) == 0);
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      MemReqM    = m_busy ? 1'b1 : ($urandom_range(0, 3) == 0);
      MemReadyM  = ($urandom_range(0, 2) == 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
